// File: rtl/lifo_pkg.sv
// Shared definitions for the 32-bit LIFO stack and its access controller.
// Contents: controller FSM state type, stack data width and depth constants.
package lifo_pkg;

  localparam int LIFO_DW    = 32;
  localparam int LIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WAIT,
    OUT
  } state_t;

endpackage

// File: rtl/lifo_access_ctrl.sv
// Initiator-side controller for the LIFO stack.
// Turns a valid/ready push stream and a valid/ready pop stream into the
// stack's single-cycle wr/rd strobes, registers popped words, tracks
// occupancy and auto-drains when the stack reports its high threshold.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_valid/s_ready/s_data   push stream (s_ready is combinational)
//   drain_en                 permits pops
//   m_valid/m_ready/m_data   pop stream (registered)
//   lifo_wr/lifo_rd/lifo_din strobes and write data to the stack
//   lifo_dout                stack read data, RD_LAT cycles after lifo_rd
//   lifo_ov/ud/low_th/high_th stack status flags
//   count                    tracked occupancy
//   err                      sticky overflow/underflow indication
module lifo_access_ctrl
  import lifo_pkg::*;
#(
  parameter int DW     = LIFO_DW,
  parameter int DEPTH  = LIFO_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DW-1:0]                s_data,
  input  logic                         drain_en,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DW-1:0]                m_data,
  output logic                         lifo_wr,
  output logic                         lifo_rd,
  output logic [DW-1:0]                lifo_din,
  input  logic [DW-1:0]                lifo_dout,
  input  logic                         lifo_ov,
  input  logic                         lifo_ud,
  input  logic                         lifo_low_th,
  input  logic                         lifo_high_th,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t     state;
  logic [2:0] wait_cnt;
  logic       pop_ok;
  logic       push;

  // Low threshold is informational only.
  logic unused_low_th;
  assign unused_low_th = lifo_low_th;

  always_comb begin
    pop_ok  = (drain_en || lifo_high_th) && (count != '0) && !m_valid;
    s_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    s_ready = !pop_ok && (count != FULL);
        OUT:     s_ready = (count != FULL);
        default: s_ready = 1'b0;
      endcase
    end
    push = s_valid && s_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      count    <= '0;
      err      <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      lifo_wr  <= 1'b0;
      lifo_rd  <= 1'b0;
      lifo_din <= '0;
    end else begin
      lifo_wr <= push;
      if (push) lifo_din <= s_data;
      lifo_rd <= 1'b0;
      err     <= err | lifo_ov | lifo_ud;

      // Pop decision and push acceptance are mutually exclusive in a cycle
      // because s_ready is held low whenever a pop is chosen.
      if (state == IDLE && pop_ok) count <= count - CW'(1);
      else if (push)               count <= count + CW'(1);

      case (state)
        IDLE: begin
          if (pop_ok) begin
            state   <= RD;
            lifo_rd <= 1'b1;
          end
        end
        RD: begin
          state    <= WAIT;
          wait_cnt <= 3'(RD_LAT - 1);
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            m_data  <= lifo_dout;
            m_valid <= 1'b1;
            state   <= OUT;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_access_ctrl.sv
module tb_lifo_access_ctrl;
  import lifo_pkg::*;

  localparam int DW = LIFO_DW;
  localparam int DEPTH = LIFO_DEPTH;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic drain_en = 1'b0;
  logic m_valid, m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic lifo_wr, lifo_rd;
  logic [DW-1:0] lifo_din, lifo_dout;
  logic lifo_ov = 1'b0, lifo_ud = 1'b0, lifo_low_th = 1'b0, lifo_high_th = 1'b0;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lifo_access_ctrl #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .drain_en(drain_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .lifo_wr(lifo_wr), .lifo_rd(lifo_rd), .lifo_din(lifo_din), .lifo_dout(lifo_dout),
    .lifo_ov(lifo_ov), .lifo_ud(lifo_ud), .lifo_low_th(lifo_low_th), .lifo_high_th(lifo_high_th),
    .count(count), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural stack with a one-cycle registered read port.
  logic [DW-1:0] stk[$];
  logic [DW-1:0] dout_r;
  assign lifo_dout = dout_r;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stk.delete();
      dout_r <= '0;
    end else begin
      if (lifo_rd && stk.size() > 0) dout_r <= stk.pop_back();
      if (lifo_wr) stk.push_back(lifo_din);
    end
  end

  // Transaction-level model of the controller: occupancy, a list of words
  // the stack should hold, and a phase counter for the single pop in flight.
  int            mcount = 0;
  logic [DW-1:0] mstack[$];
  int            ph = 0;            // 0: none, 1: rd strobe cycle, 2..1+RD_LAT: waiting
  logic [DW-1:0] pend = '0;
  bit            mvalid = 0, mwr = 0, merr = 0;
  logic [DW-1:0] mdata = '0, mdin = '0;

  always @(negedge clk) begin
    bit exp_sready, push, pop_dec;
    if (rst) begin
      exp_sready = 0;
      mcount = 0; mstack.delete(); ph = 0; mvalid = 0; mwr = 0; merr = 0;
      mdata = '0; mdin = '0;
    end else if (ph != 0) exp_sready = 0;
    else if (mvalid)      exp_sready = (mcount != DEPTH);
    else if ((drain_en || lifo_high_th) && mcount != 0) exp_sready = 0;
    else                  exp_sready = (mcount != DEPTH);

    chk("s_ready",  {31'd0, s_ready}, {31'd0, exp_sready});
    chk("lifo_wr",  {31'd0, lifo_wr}, {31'd0, mwr});
    chk("lifo_din", lifo_din, mdin);
    chk("lifo_rd",  {31'd0, lifo_rd}, {31'd0, (ph == 1)});
    chk("m_valid",  {31'd0, m_valid}, {31'd0, mvalid});
    chk("m_data",   m_data, mdata);
    chk("count",    32'(count), 32'(mcount));
    chk("err",      {31'd0, err}, {31'd0, merr});

    if (!rst) begin
      push    = s_valid && exp_sready;
      pop_dec = (ph == 0) && !mvalid && (drain_en || lifo_high_th) && (mcount != 0);
      merr    = merr | lifo_ov | lifo_ud;
      mwr     = push;
      if (push) begin
        mdin = s_data;
        mstack.push_back(s_data);
        mcount++;
      end
      if (pop_dec) begin
        mcount--;
        pend = mstack.pop_back();
        ph = 1;
      end else if (ph != 0) begin
        if (ph == 1 + RD_LAT) begin
          mvalid = 1;
          mdata  = pend;
          ph     = 0;
        end else ph++;
      end else if (mvalid && m_ready) mvalid = 0;
    end
  end

  // Event bookkeeping for the directed checks.
  int cyc = 0, last_rd = 0, last_wr = 0, wr_cnt = 0, rd_cnt = 0, wr_run = 0, wr_run_max = 0;
  logic [DW-1:0] got[$];
  always @(negedge clk) begin
    cyc++;
    if (lifo_rd) begin last_rd = cyc; rd_cnt++; end
    if (lifo_wr) begin
      last_wr = cyc; wr_cnt++; wr_run++;
      if (wr_run > wr_run_max) wr_run_max = wr_run;
    end else wr_run = 0;
    if (m_valid && m_ready) got.push_back(m_data);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic look;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int w0, mark, n;
    #1 rst = 1'b1;
    step(2);
    look();
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_lifo_wr", {31'd0, lifo_wr}, 32'd0);
    step(1);
    rst = 1'b0;
    look();
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("post_rst_count", 32'(count), 32'd0);

    // Three back-to-back pushes
    step(1);
    s_valid = 1'b1; s_data = 32'h8000_0000; step(1);
    s_data = 32'h1; step(1);
    s_data = 32'h2; step(1);
    s_valid = 1'b0;
    step(1);
    look();
    chk("push3_count", 32'(count), 32'd3);
    chk("push3_wr_cnt", 32'(wr_cnt), 32'd3);
    chk("push3_wr_run", 32'(wr_run_max), 32'd3);
    chk("push3_m_valid", {31'd0, m_valid}, 32'd0);

    // Drain in LIFO order
    step(1);
    drain_en = 1'b1; m_ready = 1'b1;
    n = 0;
    while (got.size() < 3 && n < 50) begin step(1); n++; end
    step(5);
    look();
    chk("drain_n", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("drain_0", got[0], 32'h2);
      chk("drain_1", got[1], 32'h1);
      chk("drain_2", got[2], 32'h8000_0000);
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_rd_cnt", 32'(rd_cnt), 32'd3);
    chk("drain_err", {31'd0, err}, 32'd0);

    // Fill to capacity with a held s_valid
    step(1);
    drain_en = 1'b0; m_ready = 1'b0;
    w0 = wr_cnt;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 32'h100 + 32'(i);
      step(1);
    end
    look();
    chk("full_count", 32'(count), 32'd16);
    chk("full_s_ready", {31'd0, s_ready}, 32'd0);
    chk("full_wr_cnt", 32'(wr_cnt - w0), 32'd16);
    chk("full_wr_run", 32'(wr_run_max), 32'd16);

    // Pop wins over held push, push then accepted during OUT
    step(1);
    mark = cyc;
    w0 = wr_cnt;
    s_data = 32'hABCD_0001;
    drain_en = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin step(1); n++; end
    step(3);
    look();
    chk("prio_rd_seen", {31'd0, (last_rd > mark)}, 32'd1);
    chk("prio_wr_after_rd", {31'd0, (last_wr > last_rd)}, 32'd1);
    chk("prio_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    chk("prio_m_data", m_data, 32'h10F);
    chk("prio_count", 32'(count), 32'd16);

    step(1);
    s_valid = 1'b0; m_ready = 1'b1;
    n = 0;
    while (count != 0 && n < 200) begin step(1); n++; end
    step(6);
    look();
    chk("empty_count", 32'(count), 32'd0);
    chk("empty_m_valid", {31'd0, m_valid}, 32'd0);
    if (got.size() > 0) chk("empty_last_word", got[$], 32'h100);

    // Auto-pop on high threshold
    step(1);
    drain_en = 1'b0; m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF; step(1);
    s_valid = 1'b0; lifo_high_th = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin step(1); n++; end
    look();
    chk("auto_m_valid", {31'd0, m_valid}, 32'd1);
    chk("auto_m_data", m_data, 32'hDEAD_BEEF);
    chk("auto_count", 32'(count), 32'd0);
    step(1);
    lifo_high_th = 1'b0; m_ready = 1'b1; step(1);
    m_ready = 1'b0;

    // Sticky error
    lifo_ud = 1'b1; step(1);
    lifo_ud = 1'b0; step(2);
    look();
    chk("err_set", {31'd0, err}, 32'd1);
    step(5);
    look();
    chk("err_sticky", {31'd0, err}, 32'd1);
    step(1);
    rst = 1'b1; step(1);
    look();
    chk("err_cleared", {31'd0, err}, 32'd0);
    step(1);
    rst = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
